// File: rtl/matrix_data_mem_responder_if.sv
// Bus bundle between the matrix processor / host and the data-memory responder.
//   Processor side : ar_out, bus_out, dm_en, end_process -> dm_out, status
//   Host loader    : host_in_valid/data/last -> host_in_ready
//   Host drain     : dump_base, dump_len, host_out_ready -> host_out_valid/data
//   Error          : addr_err (sticky)
// master : processor/host end (drives requests)
// slave  : memory responder end
interface matrix_data_mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [15:0]       ar_out;
   logic [DATA_W-1:0] bus_out;
   logic              dm_en;
   logic              end_process;
   logic [DATA_W-1:0] dm_out;
   logic [1:0]        status;
   logic              host_in_valid;
   logic [DATA_W-1:0] host_in_data;
   logic              host_in_last;
   logic              host_in_ready;
   logic [ADDR_W-1:0] dump_base;
   logic [ADDR_W:0]   dump_len;
   logic              host_out_valid;
   logic [DATA_W-1:0] host_out_data;
   logic              host_out_ready;
   logic              addr_err;

   modport master (
      output ar_out, bus_out, dm_en, end_process,
      output host_in_valid, host_in_data, host_in_last,
      output dump_base, dump_len, host_out_ready,
      input  dm_out, status, host_in_ready,
      input  host_out_valid, host_out_data, addr_err
   );

   modport slave (
      input  ar_out, bus_out, dm_en, end_process,
      input  host_in_valid, host_in_data, host_in_last,
      input  dump_base, dump_len, host_out_ready,
      output dm_out, status, host_in_ready,
      output host_out_valid, host_out_data, addr_err
   );
endinterface

// File: rtl/matrix_data_mem_responder.sv
// Data-memory responder for the matrix-multiplication processor.
// Loads matrix bytes from the host, services processor reads/writes during
// the run, then drains a result window back to the host.
//
// Ports:
//   clock : system clock, rising edge
//   rst   : asynchronous active-low reset
//   dm    : matrix_data_mem_responder_if.slave (processor bus, host load and
//           drain streams, status, sticky addr_err)
//
// Build option:
//   DM_WRITE_FIRST_EN : when defined, a RUN write and read to the same address
//                       in one cycle returns the new data; otherwise old data.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_LOAD       | host streams bytes into mem, status 01
// ST_RUN        | processor reads/writes, status 00
// ST_DUMP_FETCH | read mem[dump_ptr] into drain register, status 10
// ST_DUMP_VALID | drain byte presented until host takes it, status 10
// ST_DONE       | idle until reset, status 11
module matrix_data_mem_responder #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input logic                       clock,
   input logic                       rst,
   matrix_data_mem_responder_if.slave dm
);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_RUN,
      ST_DUMP_FETCH,
      ST_DUMP_VALID,
      ST_DONE
   } state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_t            state_q, state_d;
   logic [DATA_W-1:0] dm_out_q, dm_out_d;
   logic [1:0]        status_q, status_d;
   logic              host_in_ready_q, host_in_ready_d;
   logic              host_out_valid_q, host_out_valid_d;
   logic [DATA_W-1:0] host_out_data_q, host_out_data_d;
   logic              addr_err_q, addr_err_d;
   logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
   logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;
   logic [ADDR_W:0]   dump_cnt_q, dump_cnt_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              ar_out_of_range;
   logic [ADDR_W-1:0] ar_idx;

   assign ar_out_of_range = |dm.ar_out[15:ADDR_W];
   assign ar_idx          = dm.ar_out[ADDR_W-1:0];

   always_comb begin
      state_d          = state_q;
      dm_out_d         = dm_out_q;
      host_in_ready_d  = host_in_ready_q;
      host_out_valid_d = host_out_valid_q;
      host_out_data_d  = host_out_data_q;
      addr_err_d       = addr_err_q;
      load_ptr_d       = load_ptr_q;
      dump_ptr_d       = dump_ptr_q;
      dump_cnt_d       = dump_cnt_q;
      mem_we           = 1'b0;
      mem_waddr        = load_ptr_q;
      mem_wdata        = dm.host_in_data;

      case (state_q)
         ST_LOAD: begin
            dm_out_d        = '0;
            host_in_ready_d = 1'b1;
            if (dm.host_in_valid && host_in_ready_q) begin
               mem_we     = 1'b1;
               load_ptr_d = load_ptr_q + 1'b1;
               // Running off the top of memory ends the load as if last had
               // been seen, but flags it.
               if (dm.host_in_last || load_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  state_d         = ST_RUN;
                  host_in_ready_d = 1'b0;
                  if (!dm.host_in_last) begin
                     addr_err_d = 1'b1;
                  end
               end
            end
         end

         ST_RUN: begin
            if (ar_out_of_range) begin
               dm_out_d   = '0;
               addr_err_d = 1'b1;
            end else begin
               dm_out_d = mem_q[ar_idx];
               if (dm.dm_en) begin
                  mem_we    = 1'b1;
                  mem_waddr = ar_idx;
                  mem_wdata = dm.bus_out;
`ifdef DM_WRITE_FIRST_EN
                  dm_out_d  = dm.bus_out;
`endif
               end
            end
            if (dm.end_process) begin
               state_d    = ST_DUMP_FETCH;
               dump_ptr_d = dm.dump_base;
               dump_cnt_d = dm.dump_len;
            end
         end

         ST_DUMP_FETCH: begin
            if (dump_cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               host_out_data_d  = mem_q[dump_ptr_q];
               host_out_valid_d = 1'b1;
               state_d          = ST_DUMP_VALID;
            end
         end

         ST_DUMP_VALID: begin
            if (dm.host_out_ready) begin
               host_out_valid_d = 1'b0;
               dump_ptr_d       = dump_ptr_q + 1'b1;
               dump_cnt_d       = dump_cnt_q - 1'b1;
               // Leave straight for DONE after the final byte so the host sees
               // no extra fetch cycle.
               if (dump_cnt_q == (ADDR_W + 1)'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DUMP_FETCH;
               end
            end
         end

         ST_DONE: begin
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase

      case (state_d)
         ST_LOAD:       status_d = 2'b01;
         ST_RUN:        status_d = 2'b00;
         ST_DUMP_FETCH: status_d = 2'b10;
         ST_DUMP_VALID: status_d = 2'b10;
         default:       status_d = 2'b11;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_LOAD;
         dm_out_q         <= '0;
         status_q         <= 2'b01;
         host_in_ready_q  <= 1'b0;
         host_out_valid_q <= 1'b0;
         host_out_data_q  <= '0;
         addr_err_q       <= 1'b0;
         load_ptr_q       <= '0;
         dump_ptr_q       <= '0;
         dump_cnt_q       <= '0;
      end else begin
         state_q          <= state_d;
         dm_out_q         <= dm_out_d;
         status_q         <= status_d;
         host_in_ready_q  <= host_in_ready_d;
         host_out_valid_q <= host_out_valid_d;
         host_out_data_q  <= host_out_data_d;
         addr_err_q       <= addr_err_d;
         load_ptr_q       <= load_ptr_d;
         dump_ptr_q       <= dump_ptr_d;
         dump_cnt_q       <= dump_cnt_d;
      end
   end

   // Contents survive reset so the host can reload or drain selectively.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign dm.dm_out         = dm_out_q;
   assign dm.status         = status_q;
   assign dm.host_in_ready  = host_in_ready_q;
   assign dm.host_out_valid = host_out_valid_q;
   assign dm.host_out_data  = host_out_data_q;
   assign dm.addr_err       = addr_err_q;

endmodule

// File: tb/tb_matrix_data_mem_responder.sv
module tb_matrix_data_mem_responder;

   logic clock = 1'b0;
   logic rst   = 1'b0;
   always #5 clock = ~clock;

   matrix_data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) dm_if ();

   matrix_data_mem_responder #(.DEPTH(256), .ADDR_W(8), .DATA_W(8)) dut (
      .clock (clock),
      .rst   (rst),
      .dm    (dm_if)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event at %0t", name, $time);
   endtask

   // Reference model: phase, byte-addressed memory, queue of bytes still to drain.
   int         m_phase;          // 0 LOAD, 1 RUN, 2 DUMP, 3 DONE
   logic [7:0] ref_mem  [256];
   bit         ref_init [256];
   logic [7:0] drain_q  [$];
   bit         m_gap;            // DUMP: fetch cycle pending before next byte shows
   logic       m_ready, m_ov, m_err;
   logic [7:0] m_dm_out, m_od;
   bit         m_dm_known;
   int         m_lptr;

   function automatic logic [1:0] phase_status(input int p);
      case (p)
         0:       return 2'b01;
         1:       return 2'b00;
         2:       return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   task automatic model_reset();
      m_phase    = 0;
      m_ready    = 1'b0;
      m_ov       = 1'b0;
      m_od       = 8'h00;
      m_err      = 1'b0;
      m_dm_out   = 8'h00;
      m_dm_known = 1'b1;
      m_lptr     = 0;
      m_gap      = 1'b0;
      drain_q.delete();
   endtask

   task automatic model_step();
      int         a;
      logic [7:0] rd;
      bit         rd_known;
      case (m_phase)
         0: begin
            if (m_ready && dm_if.host_in_valid) begin
               ref_mem[m_lptr]  = dm_if.host_in_data;
               ref_init[m_lptr] = 1'b1;
               if (dm_if.host_in_last || m_lptr == 255) begin
                  if (!dm_if.host_in_last) m_err = 1'b1;
                  m_phase = 1;
                  m_ready = 1'b0;
               end
               m_lptr = (m_lptr + 1) % 256;
            end else begin
               m_ready = 1'b1;
            end
         end
         1: begin
            a = int'(dm_if.ar_out);
            if (a >= 256) begin
               m_dm_out   = 8'h00;
               m_dm_known = 1'b1;
               m_err      = 1'b1;
            end else begin
               rd       = ref_mem[a];
               rd_known = ref_init[a];
               if (dm_if.dm_en) begin
`ifdef DM_WRITE_FIRST_EN
                  rd       = dm_if.bus_out;
                  rd_known = 1'b1;
`endif
                  ref_mem[a]  = dm_if.bus_out;
                  ref_init[a] = 1'b1;
               end
               m_dm_out   = rd;
               m_dm_known = rd_known;
            end
            if (dm_if.end_process) begin
               m_phase = 2;
               m_gap   = 1'b1;
               drain_q.delete();
               for (int i = 0; i < int'(dm_if.dump_len); i++)
                  drain_q.push_back(ref_mem[(int'(dm_if.dump_base) + i) % 256]);
            end
         end
         2: begin
            if (m_gap) begin
               if (drain_q.size() == 0) m_phase = 3;
               else begin
                  m_ov  = 1'b1;
                  m_od  = drain_q[0];
                  m_gap = 1'b0;
               end
            end else if (dm_if.host_out_ready) begin
               void'(drain_q.pop_front());
               m_ov = 1'b0;
               if (drain_q.size() == 0) m_phase = 3;
               else m_gap = 1'b1;
            end
         end
         default: begin
         end
      endcase
   endtask

   always @(posedge clock) begin
      if (rst) model_step();
   end

   always @(negedge clock) begin
      chk("status", dm_if.status, phase_status(m_phase));
      chk("host_in_ready", dm_if.host_in_ready, m_ready);
      chk("host_out_valid", dm_if.host_out_valid, m_ov);
      chk("addr_err", dm_if.addr_err, m_err);
      if (m_dm_known) chk("dm_out", dm_if.dm_out, m_dm_out);
      if (m_ov) chk("host_out_data", dm_if.host_out_data, m_od);
   end

   logic [7:0] got [$];
   logic [7:0] prev_data;
   logic       prev_valid, prev_ready;
   logic [7:0] exp_drain [4];
   int         n;

   initial begin
      for (int i = 0; i < 256; i++) ref_init[i] = 1'b0;
      model_reset();
      dm_if.ar_out         = 16'h0000;
      dm_if.bus_out        = 8'h00;
      dm_if.dm_en          = 1'b0;
      dm_if.end_process    = 1'b0;
      dm_if.host_in_valid  = 1'b0;
      dm_if.host_in_data   = 8'h00;
      dm_if.host_in_last   = 1'b0;
      dm_if.dump_base      = 8'h00;
      dm_if.dump_len       = 9'd0;
      dm_if.host_out_ready = 1'b0;

      repeat (2) @(negedge clock);
      chk("reset_status", dm_if.status, 2'b01);
      chk("reset_ready", dm_if.host_in_ready, 1'b0);
      chk("reset_dm_out", dm_if.dm_out, 8'h00);
      rst = 1'b1;
      @(negedge clock);
      chk("ready_after_release", dm_if.host_in_ready, 1'b1);

      // Load 0x01..0x08, last on 0x08
      for (int i = 0; i < 8; i++) begin
         dm_if.host_in_valid = 1'b1;
         dm_if.host_in_data  = 8'(i + 1);
         dm_if.host_in_last  = (i == 7);
         @(negedge clock);
      end
      dm_if.host_in_valid = 1'b0;
      dm_if.host_in_last  = 1'b0;
      chk("load_done_status", dm_if.status, 2'b00);
      chk("load_done_ready", dm_if.host_in_ready, 1'b0);

      // RUN reads and writes
      dm_if.ar_out = 16'h0003;
      @(negedge clock);
      chk("read_3", dm_if.dm_out, 8'h04);
      dm_if.dm_en = 1'b1;
      dm_if.ar_out = 16'h00FE; dm_if.bus_out = 8'hE1; @(negedge clock);
      dm_if.ar_out = 16'h00FF; dm_if.bus_out = 8'hE2; @(negedge clock);
      dm_if.ar_out = 16'h0010; dm_if.bus_out = 8'hA5; @(negedge clock);
      dm_if.dm_en = 1'b0;
      @(negedge clock);
      chk("read_10", dm_if.dm_out, 8'hA5);
      dm_if.ar_out = 16'h0002; dm_if.dm_en = 1'b1; dm_if.bus_out = 8'h55;
      @(negedge clock);
`ifdef DM_WRITE_FIRST_EN
      chk("same_cycle_rw", dm_if.dm_out, 8'h55);
`else
      chk("same_cycle_rw", dm_if.dm_out, 8'h03);
`endif
      dm_if.dm_en = 1'b0;
      @(negedge clock);
      chk("read_2_after_write", dm_if.dm_out, 8'h55);
      dm_if.ar_out = 16'h0100; dm_if.dm_en = 1'b1; dm_if.bus_out = 8'h77;
      @(negedge clock);
      chk("oor_dm_out", dm_if.dm_out, 8'h00);
      chk("oor_addr_err", dm_if.addr_err, 1'b1);
      dm_if.dm_en = 1'b0; dm_if.ar_out = 16'h0000;
      @(negedge clock);
      chk("oor_no_alias_write", dm_if.dm_out, 8'h01);
      chk("addr_err_sticky", dm_if.addr_err, 1'b1);

      // Drain FE,FF,00,01 with a stalling host
      dm_if.dump_base = 8'hFE; dm_if.dump_len = 9'd4; dm_if.end_process = 1'b1;
      @(negedge clock);
      dm_if.end_process = 1'b0;
      n = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
      while (got.size() < 4 && n < 100) begin
         if (dm_if.host_out_valid && prev_valid && !prev_ready)
            chk("stall_stable", dm_if.host_out_data, prev_data);
         dm_if.host_out_ready = (n % 3 != 0);
         if (dm_if.host_out_valid && dm_if.host_out_ready) got.push_back(dm_if.host_out_data);
         prev_valid = dm_if.host_out_valid;
         prev_ready = dm_if.host_out_ready;
         prev_data  = dm_if.host_out_data;
         @(negedge clock);
         n++;
      end
      dm_if.host_out_ready = 1'b0;
      if (n >= 100) fail_now("drain_timeout");
      chk("dump_done_status", dm_if.status, 2'b11);
      chk("dump_done_valid", dm_if.host_out_valid, 1'b0);
      exp_drain[0] = 8'hE1; exp_drain[1] = 8'hE2; exp_drain[2] = 8'h01; exp_drain[3] = 8'h02;
      for (int i = 0; i < 4; i++)
         chk("drain_byte", (i < got.size()) ? got[i] : 8'hXX, exp_drain[i]);

      // DONE ignores every strobe
      dm_if.host_in_valid = 1'b1; dm_if.dm_en = 1'b1; dm_if.end_process = 1'b1;
      dm_if.ar_out = 16'h0005;
      repeat (3) @(negedge clock);
      chk("done_holds", dm_if.status, 2'b11);
      dm_if.host_in_valid = 1'b0; dm_if.dm_en = 1'b0; dm_if.end_process = 1'b0;
      dm_if.ar_out = 16'h0000;

      // Reset, then overflow load of all 256 bytes without last
      #2 rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 256; i++) begin
         dm_if.host_in_valid = 1'b1;
         dm_if.host_in_data  = 8'(i) ^ 8'h5A;
         @(negedge clock);
      end
      dm_if.host_in_valid = 1'b0;
      chk("overflow_status", dm_if.status, 2'b00);
      chk("overflow_addr_err", dm_if.addr_err, 1'b1);

      // Reset while a drain byte is presented
      dm_if.dump_base = 8'h10; dm_if.dump_len = 9'd3; dm_if.end_process = 1'b1;
      @(negedge clock);
      dm_if.end_process = 1'b0;
      n = 0;
      while (!dm_if.host_out_valid && n < 10) begin
         @(negedge clock);
         n++;
      end
      if (n >= 10) fail_now("valid_timeout");
      chk("drain_first_after_overflow", dm_if.host_out_data, 8'h4A);
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("reset_mid_dump_valid", dm_if.host_out_valid, 1'b0);
      chk("reset_mid_dump_status", dm_if.status, 2'b01);
      chk("reset_clears_addr_err", dm_if.addr_err, 1'b0);
      @(negedge clock);
      rst = 1'b1;
      @(negedge clock);

      // Zero-length dump goes straight to DONE
      for (int i = 0; i < 2; i++) begin
         dm_if.host_in_valid = 1'b1;
         dm_if.host_in_data  = (i == 0) ? 8'h11 : 8'h22;
         dm_if.host_in_last  = (i == 1);
         @(negedge clock);
      end
      dm_if.host_in_valid = 1'b0; dm_if.host_in_last = 1'b0;
      chk("reload_status", dm_if.status, 2'b00);
      dm_if.dump_base = 8'h00; dm_if.dump_len = 9'd0; dm_if.end_process = 1'b1;
      @(negedge clock);
      dm_if.end_process = 1'b0;
      chk("zero_len_dump_status", dm_if.status, 2'b10);
      @(negedge clock);
      chk("zero_len_done_status", dm_if.status, 2'b11);
      chk("zero_len_no_valid", dm_if.host_out_valid, 1'b0);
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
